// File: rtl/sdram_init_pkg.sv
// Shared types and helpers for the SDRAM power-up sequencer.
package sdram_init_pkg;

    // SDRAM commands, encoded as {ras_n, cas_n, we_n}
    typedef enum logic [2:0] {
        CMD_MRS       = 3'b000,
        CMD_AREF      = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_NOP       = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        WAIT_NOP,
        PRE,
        WAIT_TRP,
        AREF,
        WAIT_TRFC,
        MRS,
        WAIT_TMRD,
        DONE
    } state_e;

    typedef struct packed {
        logic ras_n;
        logic cas_n;
        logic we_n;
    } pins_t;

    function automatic pins_t cmd_to_pins(input cmd_e cmd);
        pins_t p;
        {p.ras_n, p.cas_n, p.we_n} = cmd;
        return p;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// Loadable down-counter that stops at zero; shared wait timer of the init sequencer.
module sdram_init_timer
    import sdram_init_pkg::*;
#(
    parameter int unsigned     W       = 10,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority over counting; the count saturates at zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: NOP wait, PRECHARGE-ALL, N x AUTO-REFRESH, LOAD-MODE, then init_done.
module sdram_init_seq
    import sdram_init_pkg::*;
#(
    parameter int unsigned NOP_CYCLES    = 600,
    parameter int unsigned TRP_CYCLES    = 3,
    parameter int unsigned TRFC_CYCLES   = 7,
    parameter int unsigned TMRD_CYCLES   = 2,
    parameter int unsigned REFRESH_COUNT = 2,
    parameter int unsigned ADDR_W        = 12,
    parameter logic [ADDR_W-1:0] MODE_REG = 'h033
) (
    input  logic              sdram_clk,
    input  logic              sdram_reset,
    input  logic              init_req,
    output logic              sdr_cke,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [1:0]        sdr_ba,
    output logic [ADDR_W-1:0] sdr_addr,
    output logic              init_done
);

    localparam int unsigned CNT_W = $clog2(max4(NOP_CYCLES, TRP_CYCLES, TRFC_CYCLES, TMRD_CYCLES) + 1);
    localparam int unsigned REF_W = $clog2(REFRESH_COUNT + 1);

    state_e              state_q, state_d;
    logic [REF_W-1:0]    ref_q, ref_d;
    logic                cke_q;
    logic                cs_n_q;
    cmd_e                cmd_q, cmd_d;
    logic [1:0]          ba_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                done_q, done_d;

    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_load_val;
    logic                tmr_en;
    logic                tmr_zero;
    pins_t               pins;

    sdram_init_timer #(
        .W       (CNT_W),
        .RST_VAL (CNT_W'(NOP_CYCLES - 1))
    ) u_timer (
        .clk_i      (sdram_clk),
        .rst_i      (sdram_reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    // Next state, timer control and the registered command for the coming cycle
    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        cmd_d        = CMD_NOP;
        addr_d       = '0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
        // cke_q low marks cycle 0 after reset: its NOP is the first counted one,
        // so the timer keeps its reset value (NOP_CYCLES-1) for that cycle.
        if (cke_q) begin
            tmr_en = 1'b1;
            case (state_q)
                WAIT_NOP:  if (tmr_zero) state_d = PRE;
                PRE:       if (tmr_zero) state_d = WAIT_TRP;
                WAIT_TRP:  if (tmr_zero) state_d = AREF;
                AREF:      if (tmr_zero) state_d = WAIT_TRFC;
                WAIT_TRFC: if (tmr_zero) state_d = (ref_q != '0) ? AREF : MRS;
                MRS:       if (tmr_zero) state_d = WAIT_TMRD;
                WAIT_TMRD: if (tmr_zero) state_d = DONE;
                DONE:      if (init_req) state_d = WAIT_NOP;
                default:   state_d = WAIT_NOP;
            endcase
            if (state_d != state_q) begin
                tmr_load = 1'b1;
                case (state_d)
                    WAIT_NOP: begin
                        tmr_load_val = CNT_W'(NOP_CYCLES - 1);
                        ref_d        = REF_W'(REFRESH_COUNT);
                    end
                    PRE: begin
                        cmd_d      = CMD_PRECHARGE;
                        addr_d[10] = 1'b1;
                    end
                    WAIT_TRP:  tmr_load_val = CNT_W'(TRP_CYCLES - 1);
                    AREF: begin
                        cmd_d = CMD_AREF;
                        ref_d = ref_q - REF_W'(1);
                    end
                    WAIT_TRFC: tmr_load_val = CNT_W'(TRFC_CYCLES - 1);
                    MRS: begin
                        cmd_d  = CMD_MRS;
                        addr_d = MODE_REG;
                    end
                    WAIT_TMRD: tmr_load_val = CNT_W'(TMRD_CYCLES - 1);
                    default: ;
                endcase
            end
        end
        done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            state_q <= WAIT_NOP;
            ref_q   <= REF_W'(REFRESH_COUNT);
            cke_q   <= 1'b0;
            cs_n_q  <= 1'b0;
            cmd_q   <= CMD_NOP;
            ba_q    <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            cke_q   <= 1'b1;
            cs_n_q  <= 1'b0;
            cmd_q   <= cmd_d;
            ba_q    <= '0;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign pins      = cmd_to_pins(cmd_q);
    assign sdr_cke   = cke_q;
    assign sdr_cs_n  = cs_n_q;
    assign sdr_ras_n = pins.ras_n;
    assign sdr_cas_n = pins.cas_n;
    assign sdr_we_n  = pins.we_n;
    assign sdr_ba    = ba_q;
    assign sdr_addr  = addr_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: three parameterisations checked every cycle against a timeline model.
module tb_sdram_init_seq;

    logic        clk = 1'b0;
    logic [2:0]  rst_v = 3'b111;
    logic [2:0]  req_v = 3'b000;

    int n_cmp = 0;
    int n_bad = 0;

    // per-instance parameters: 0 = defaults, 1 = 4 refreshes with tRFC=2, 2 = all minimal
    int p_nop  [3] = '{600, 600, 1};
    int p_trp  [3] = '{3, 3, 1};
    int p_trfc [3] = '{7, 2, 1};
    int p_tmrd [3] = '{2, 2, 1};
    int p_rc   [3] = '{2, 4, 1};

    // cycle index since reset release (-1 while in reset), per instance
    int   cyc [3] = '{-1, -1, -1};
    logic started = 1'b0;

    logic        cke   [3];
    logic        cs_n  [3];
    logic        ras_n [3];
    logic        cas_n [3];
    logic        we_n  [3];
    logic [1:0]  ba    [3];
    logic [11:0] addr  [3];
    logic        done  [3];
    logic [19:0] act   [3];

    always #5 clk = ~clk;

    sdram_init_seq u_dut0 (
        .sdram_clk(clk), .sdram_reset(rst_v[0]), .init_req(req_v[0]),
        .sdr_cke(cke[0]), .sdr_cs_n(cs_n[0]), .sdr_ras_n(ras_n[0]), .sdr_cas_n(cas_n[0]),
        .sdr_we_n(we_n[0]), .sdr_ba(ba[0]), .sdr_addr(addr[0]), .init_done(done[0])
    );

    sdram_init_seq #(.REFRESH_COUNT(4), .TRFC_CYCLES(2)) u_dut1 (
        .sdram_clk(clk), .sdram_reset(rst_v[1]), .init_req(req_v[1]),
        .sdr_cke(cke[1]), .sdr_cs_n(cs_n[1]), .sdr_ras_n(ras_n[1]), .sdr_cas_n(cas_n[1]),
        .sdr_we_n(we_n[1]), .sdr_ba(ba[1]), .sdr_addr(addr[1]), .init_done(done[1])
    );

    sdram_init_seq #(.NOP_CYCLES(1), .TRP_CYCLES(1), .TRFC_CYCLES(1), .TMRD_CYCLES(1),
                     .REFRESH_COUNT(1)) u_dut2 (
        .sdram_clk(clk), .sdram_reset(rst_v[2]), .init_req(req_v[2]),
        .sdr_cke(cke[2]), .sdr_cs_n(cs_n[2]), .sdr_ras_n(ras_n[2]), .sdr_cas_n(cas_n[2]),
        .sdr_we_n(we_n[2]), .sdr_ba(ba[2]), .sdr_addr(addr[2]), .init_done(done[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_act
        assign act[g] = {cke[g], cs_n[g], ras_n[g], cas_n[g], we_n[g], ba[g], addr[g], done[g]};
    end

    function automatic int done_time(input int i);
        return p_nop[i] + 1 + p_trp[i] + p_rc[i] * (1 + p_trfc[i]) + 1 + p_tmrd[i];
    endfunction

    // Expected pins {cke, cs_n, ras_n, cas_n, we_n, ba, addr, done} at cycle c of instance i
    function automatic logic [19:0] exp_vec(input int i, input int c);
        logic [2:0]  cmd;
        logic [11:0] a;
        int t_aref, t_mrs;
        if (c < 0) return {1'b0, 1'b0, 3'b111, 2'b00, 12'h000, 1'b0};
        cmd    = 3'b111;
        a      = 12'h000;
        t_aref = p_nop[i] + 1 + p_trp[i];
        t_mrs  = t_aref + p_rc[i] * (1 + p_trfc[i]);
        if (c == p_nop[i]) begin
            cmd = 3'b010;
            a   = 12'h400;
        end
        for (int k = 0; k < p_rc[i]; k++)
            if (c == t_aref + k * (1 + p_trfc[i])) cmd = 3'b001;
        if (c == t_mrs) begin
            cmd = 3'b000;
            a   = 12'h033;
        end
        return {1'b1, 1'b0, cmd, 2'b00, a, (c >= done_time(i))};
    endfunction

    // Timeline model: advance, restart on reset release or accepted init_req
    always @(posedge clk) begin
        started <= 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i])                                  cyc[i] <= -1;
            else if (cyc[i] < 0)                           cyc[i] <= 0;
            else if (cyc[i] >= done_time(i) && req_v[i])   cyc[i] <= 0;
            else                                           cyc[i] <= cyc[i] + 1;
        end
    end

    // Every-cycle compare of all pins of all instances
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                logic [19:0] e;
                e = exp_vec(i, cyc[i]);
                n_cmp++;
                if (act[i] !== e) begin
                    n_bad++;
                    $display("FAIL pins dut%0d cyc=%0d got=%h want=%h", i, cyc[i], act[i], e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic wait_cyc(input int i, input int target);
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            #1;
            if (cyc[i] == target) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL timeout dut%0d got=%0d want=%0d", i, cyc[i], target);
    endtask

    task automatic pulse_req(input int i);
        req_v[i] = 1'b1;
        @(posedge clk);
        #1;
        req_v[i] = 1'b0;
    endtask

    initial begin
        // model pinned against hand-computed timelines
        chk("m_pre0",   exp_vec(0, 600), {1'b1, 1'b0, 3'b010, 2'b00, 12'h400, 1'b0});
        chk("m_aref0",  exp_vec(0, 612), {1'b1, 1'b0, 3'b001, 2'b00, 12'h000, 1'b0});
        chk("m_mrs0",   exp_vec(0, 620), {1'b1, 1'b0, 3'b000, 2'b00, 12'h033, 1'b0});
        chk("m_done0",  done_time(0), 623);
        chk("m_aref1",  exp_vec(1, 613), {1'b1, 1'b0, 3'b001, 2'b00, 12'h000, 1'b0});
        chk("m_done1",  done_time(1), 619);
        chk("m_mrs2",   exp_vec(2, 5),   {1'b1, 1'b0, 3'b000, 2'b00, 12'h033, 1'b0});
        chk("m_done2",  done_time(2), 7);

        repeat (5) @(posedge clk);
        #1;
        chk("rst_cke0", cke[0], 0);
        chk("rst_ras0", {ras_n[0], cas_n[0], we_n[0]}, 3'b111);
        rst_v = 3'b000;

        // minimal instance: re-initialise after done
        wait_cyc(2, 10);
        pulse_req(2);
        chk("req2_done", done[2], 0);
        chk("req2_cyc", cyc[2], 0);

        // init_req during WAIT_NOP is ignored
        wait_cyc(0, 300);
        pulse_req(0);
        chk("done2_again", done[2], 1);
        wait_cyc(0, 600);
        chk("pre0_cmd", {ras_n[0], cas_n[0], we_n[0]}, 3'b010);
        chk("pre0_a10", addr[0][10], 1);

        // reset for one cycle in the middle of tRFC
        wait_cyc(0, 606);
        rst_v[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_cke", cke[0], 0);
        chk("midrst_cmd", {ras_n[0], cas_n[0], we_n[0]}, 3'b111);
        rst_v[0] = 1'b0;

        wait_cyc(1, 613);
        chk("aref1_613", {ras_n[1], cas_n[1], we_n[1]}, 3'b001);
        wait_cyc(1, 619);
        chk("done1_619", done[1], 1);

        wait_cyc(0, 600);
        chk("pre0_again", {ras_n[0], cas_n[0], we_n[0]}, 3'b010);
        wait_cyc(0, 622);
        chk("done0_622", done[0], 0);
        wait_cyc(0, 623);
        chk("done0_623", done[0], 1);

        // accepted re-initialisation from DONE
        wait_cyc(0, 630);
        pulse_req(0);
        chk("req0_done", done[0], 0);
        chk("req0_cke", cke[0], 1);
        wait_cyc(0, 600);
        chk("pre0_reinit", {ras_n[0], cas_n[0], we_n[0]}, 3'b010);
        wait_cyc(0, 623);
        chk("done0_reinit", done[0], 1);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
- Generates the SDRAM power-up command sequence on the sdr_* command pins: stable NOP wait, PRECHARGE-ALL, N x AUTO-REFRESH, LOAD-MODE-REGISTER, then init_done.
- Sits in the SDRAM controller between reset logic and the command mux; owns the pins until init_done, then the main scheduler takes over.
- Its output is exactly the sequence the team's whitebox init assertions check.

Parameters:
- NOP_CYCLES, 600, NOP cycles after reset release before PRECHARGE (>=1)
- TRP_CYCLES, 3, NOP cycles after PRECHARGE (>=1)
- TRFC_CYCLES, 7, NOP cycles after each AUTO-REFRESH (>=1)
- TMRD_CYCLES, 2, NOP cycles after LOAD-MODE before done (>=1)
- REFRESH_COUNT, 2, number of AUTO-REFRESH commands (>=1)
- ADDR_W, 12, sdr_addr width (>=11)
- MODE_REG, 12'h033, value driven on sdr_addr during LOAD-MODE (CL3, BL8, sequential)

Ports:
- sdram_clk  input  1  clock
- sdram_reset  input  1  synchronous, active-high reset
- init_req  input  1  one-cycle pulse requesting re-initialisation; honoured only while init_done=1
- sdr_cke  output  1  clock enable
- sdr_cs_n  output  1  chip select
- sdr_ras_n  output  1  RAS
- sdr_cas_n  output  1  CAS
- sdr_we_n  output  1  WE
- sdr_ba  output  2  bank address
- sdr_addr  output  ADDR_W  address / mode bus
- init_done  output  1  high once the sequence is complete; held until reset or accepted init_req

Behaviour:
- Interface: one clock, sdram_clk; reset is synchronous and active-high (sdram_reset). All outputs are registered.
- Reset values: cke=0, cs_n=0, ras_n/cas_n/we_n=1 (NOP), ba=0, addr=0, init_done=0. The state machine goes to WAIT_NOP with its counter loaded to NOP_CYCLES-1.
- Command encoding {ras_n,cas_n,we_n}: NOP=111, PRECHARGE=010, AREF=001, MRS=000.
- Every command lasts exactly one cycle. All other cycles carry NOP with ba=0 and addr=0.
- Cycle 0 is the first rising edge with sdram_reset=0. sdr_cke rises at cycle 0 and stays 1.
- FSM states, with the command issued on entry (via registered outputs):
  - WAIT_NOP: NOP_CYCLES NOPs, cycles 0..NOP_CYCLES-1, then go to PRE.
  - PRE: PRECHARGE with addr[10]=1 (all banks), then TRP_CYCLES NOPs in WAIT_TRP.
  - AREF: AUTO-REFRESH, then TRFC_CYCLES NOPs in WAIT_TRFC.
  - Refresh counter: decrements on each AREF. If it is nonzero after WAIT_TRFC, go to AREF again; otherwise go to MRS.
  - MRS: LOAD-MODE with addr=MODE_REG, ba=0, then TMRD_CYCLES NOPs in WAIT_TMRD.
  - DONE: init_done=1 starting the cycle after the last TMRD NOP. Pins held at NOP, cke=1.
- Single shared down-counter, width $clog2(max timing param + 1). It is reloaded on every state entry and the state exits when count==0. No wrap-around is possible.
- init_req:
  - In DONE: init_done=0 on the next cycle, FSM re-enters WAIT_NOP with the full NOP_CYCLES, cke stays 1.
  - In any other state: ignored, with no effect on timing.
- Reset mid-sequence: the next edge returns every output to its reset value and the FSM to WAIT_NOP. The sequence restarts from cycle 0 after release.
- Reset and init_req in the same cycle: reset wins.
- Total latency with defaults: init_done rises at cycle NOP+1+TRP+REFRESH_COUNT*(1+TRFC)+1+TMRD = 623.

Decomposition:
- Package sdram_init_pkg:
  - cmd_e enum (NOP, PRECHARGE, AREF, MRS) with pin encodings
  - state_e enum (WAIT_NOP, PRE, WAIT_TRP, AREF, WAIT_TRFC, MRS, WAIT_TMRD, DONE)
  - helper function cmd_to_pins
- One sub-module, sdram_init_timer: loadable down-counter with load, load_val and zero outputs.

Test Plan:
- Defaults, reset high 5 cycles then low -> cycles 0-599 NOP with cke=1. PRECHARGE at 600 with addr[10]=1. AREF at 604 and 612. MRS at 620 with addr=12'h033. init_done=1 from cycle 623. No non-NOP command at any other cycle.
- REFRESH_COUNT=4, TRFC_CYCLES=2 -> AREF at cycles 604, 607, 610, 613. MRS at 616. init_done at 619.
- Reset asserted at cycle 606 (mid-TRFC) for 1 cycle -> next edge: NOP, cke=0, init_done=0. After release, PRECHARGE again exactly 600 cycles later.
- init_req pulsed at cycle 630 -> init_done=0 at 631. PRECHARGE 600 cycles after re-entry. init_done again 623 cycles after re-entry.
- init_req pulsed at cycle 300 (during WAIT_NOP) -> no change; PRECHARGE still at 600.
- NOP_CYCLES=1, TRP=TRFC=TMRD=1, REFRESH_COUNT=1 -> PRE at 1, AREF at 3, MRS at 5, init_done at 7. Whitebox NOP-stability assertion with length matched passes.
